// File: rtl/pi_spi_pkg.sv
// Shared definitions for the PET bus SPI command master: FSM state codes, frame constants
// and the frame builder that pi_register tests reuse.
package pi_spi_pkg;

  typedef logic [2:0] spi_state_t;

  localparam spi_state_t ST_IDLE  = 3'd0;
  localparam spi_state_t ST_SETUP = 3'd1;
  localparam spi_state_t ST_SHIFT = 3'd2;
  localparam spi_state_t ST_HOLD  = 3'd3;
  localparam spi_state_t ST_GAP   = 3'd4;

  localparam int unsigned PI_SPI_FRAME_BITS = 32;
  localparam logic        PI_SPI_RW_READ    = 1'b1;

  // Byte layout: {rw_b, 6'b0, addr[16]}, addr[15:8], addr[7:0], data (0x00 on reads).
  function automatic logic [31:0] pi_spi_frame(input logic        rw_b,
                                               input logic [16:0] addr,
                                               input logic [7:0]  data);
    logic [7:0] last_byte;
    last_byte = (rw_b == PI_SPI_RW_READ) ? 8'h00 : data;
    return {rw_b, 6'b000000, addr[16], addr[15:0], last_byte};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK phase counter: divides sys_clk into CLK_DIV-cycle phases, owns the SCLK level and
// emits one-cycle rise/fall strobes on the edge that changes it.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_en_i,
  input  logic rise_en_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam int unsigned     CntW     = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;

  always_comb begin
    tick_o = count_en_i && (cnt_q == CntLast);
    rise_o = tick_o && rise_en_i && !sclk_q;
    fall_o = tick_o && sclk_q;
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clear_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (count_en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      if (rise_o) begin
        sclk_d = 1'b1;
      end else if (fall_o) begin
        sclk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/pi_spi_master.sv
// SPI mode-0 master issuing one 32-bit PET bus command frame per accepted request.
// Define PI_SPI_MASTER_MISO_EN to build MISO capture; otherwise rd_data is constant 0x00.
module pi_spi_master
  import pi_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw_b,
  input  logic [16:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  if (CLK_DIV == 0 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("pi_spi_master: CLK_DIV must be in 1..255");
  end

  spi_state_t  state_q, state_d;
  logic [31:0] frame_q, frame_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;

  logic accept;
  logic count_en;
  logic rise_en;
  logic tick;
  logic sclk_rise;
  logic sclk_fall;
  logic bits_done;

  assign accept    = cmd_valid && ready_q;
  assign bits_done = (bit_cnt_q == 6'(PI_SPI_FRAME_BITS));
  assign count_en  = (state_q != ST_IDLE);
  assign rise_en   = (state_q == ST_SETUP) || ((state_q == ST_SHIFT) && !bits_done);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i      (sys_clk),
    .rst_ni     (sys_reset_n),
    .clear_i    (accept),
    .count_en_i (count_en),
    .rise_en_i  (rise_en),
    .tick_o     (tick),
    .rise_o     (sclk_rise),
    .fall_o     (sclk_fall),
    .sclk_o     (spi_sclk)
  );

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          frame_d   = pi_spi_frame(cmd_rw_b, cmd_addr, cmd_data);
          mosi_d    = frame_d[31];
          cs_n_d    = 1'b0;
          ready_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // The low phase after the 32nd fall completes before HOLD starts.
        if (sclk_fall) begin
          frame_d   = {frame_q[30:0], 1'b0};
          mosi_d    = frame_q[30];
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else if (tick && bits_done) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;

`ifdef PI_SPI_MASTER_MISO_EN
  logic [7:0] rx_q;
  logic [7:0] rd_data_q;
  logic       rd_frame_q;

  // rx_q ends the frame holding the last eight samples, i.e. the byte 3 period.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_frame_q <= 1'b0;
    end else begin
      if (accept) begin
        rd_frame_q <= (cmd_rw_b == PI_SPI_RW_READ);
      end
      if (sclk_rise) begin
        rx_q <= {rx_q[6:0], spi_miso};
      end
      if ((state_q == ST_HOLD) && tick && rd_frame_q) begin
        rd_data_q <= rx_q;
      end
    end
  end

  assign rd_data = rd_data_q;
`else
  logic unused_miso;
  assign unused_miso = ^{spi_miso, sclk_rise};
  assign rd_data     = 8'h00;
`endif

endmodule

// File: tb/tb_pi_spi_master.sv
// Self-checking bench for pi_spi_master: CLK_DIV=2 and CLK_DIV=1 instances, directed test-plan
// frames plus random frames checked against a frame/timing model derived from the byte layout.
module tb_pi_spi_master;

  localparam int unsigned D_A = 2;
  localparam int unsigned D_B = 1;

  logic        sys_clk     = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic        cmd_rw_b    = 1'b0;
  logic [16:0] cmd_addr    = '0;
  logic [7:0]  cmd_data    = '0;
  logic        spi_miso    = 1'b0;
  logic        valid_a     = 1'b0;
  logic        valid_b     = 1'b0;

  logic       ready_a, done_a, sclk_a, cs_n_a, mosi_a;
  logic       ready_b, done_b, sclk_b, cs_n_b, mosi_b;
  logic [7:0] rd_a, rd_b;

  always #5 sys_clk = ~sys_clk;

  pi_spi_master #(.CLK_DIV(D_A)) dut_a (
    .sys_clk (sys_clk), .sys_reset_n (sys_reset_n),
    .cmd_valid (valid_a), .cmd_ready (ready_a), .cmd_rw_b (cmd_rw_b),
    .cmd_addr (cmd_addr), .cmd_data (cmd_data), .done (done_a), .rd_data (rd_a),
    .spi_sclk (sclk_a), .spi_cs_n (cs_n_a), .spi_mosi (mosi_a), .spi_miso (spi_miso)
  );

  pi_spi_master #(.CLK_DIV(D_B)) dut_b (
    .sys_clk (sys_clk), .sys_reset_n (sys_reset_n),
    .cmd_valid (valid_b), .cmd_ready (ready_b), .cmd_rw_b (cmd_rw_b),
    .cmd_addr (cmd_addr), .cmd_data (cmd_data), .done (done_b), .rd_data (rd_b),
    .spi_sclk (sclk_b), .spi_cs_n (cs_n_b), .spi_mosi (mosi_b), .spi_miso (spi_miso)
  );

  // Monitor mux: which instance the current step observes.
  logic       mon_sel = 1'b0;
  logic       mon_ready, mon_done, mon_sclk, mon_cs_n, mon_mosi;
  logic [7:0] mon_rd;

  always_comb begin
    mon_ready = mon_sel ? ready_b : ready_a;
    mon_done  = mon_sel ? done_b  : done_a;
    mon_sclk  = mon_sel ? sclk_b  : sclk_a;
    mon_cs_n  = mon_sel ? cs_n_b  : cs_n_a;
    mon_mosi  = mon_sel ? mosi_b  : mosi_a;
    mon_rd    = mon_sel ? rd_b    : rd_a;
  end

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [7:0]  exp_rd [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_frame(input logic rw, input logic [16:0] addr,
                                              input logic [7:0] data);
    logic [31:0] f;
    f = rw ? 32'h8000_0000 : 32'h0;
    f = f + (32'(addr[16]) * 32'h0100_0000) + (32'(addr[15:0]) * 32'h100);
    if (!rw) f = f + 32'(data);
    return f;
  endfunction

  // Present a command and wait for the accept edge; later field changes must not matter.
  task automatic start(input bit sel, input logic rw, input logic [16:0] addr,
                       input logic [7:0] data, input bit hold);
    @(negedge sys_clk);
    mon_sel  = sel;
    cmd_rw_b = rw;
    cmd_addr = addr;
    cmd_data = data;
    spi_miso = 1'b0;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge sys_clk);
    #1;
    if (!hold) begin
      valid_a  = 1'b0;
      valid_b  = 1'b0;
      cmd_rw_b = ~rw;
      cmd_addr = 17'($urandom);
      cmd_data = 8'($urandom);
    end
  endtask

  // Observe one frame from the first sample after accept; cycle c is the value registered on
  // edge c, which the timing table calls edge c+1.
  task automatic watch(input bit sel, input logic rw, input logic [31:0] frame,
                       input logic [7:0] resp, input bit already, input bit gap_chk);
    int unsigned d;
    int          c, done_c, last_chg, rises, falls, gap_c;
    int          stable_bad, sclk_bad, ready_bad, extra_done;
    logic        prev_sclk, prev_mosi, ready_at, cs_at_done;
    logic [7:0]  rd_at_done;
    logic [31:0] got, resp_w;
    bit          fin;
    d = sel ? D_B : D_A;
    resp_w = {24'h0, resp};
    c = 0; done_c = -1; last_chg = 0; rises = 0; falls = 0; gap_c = -1;
    stable_bad = 0; sclk_bad = 0; ready_bad = 0; extra_done = 0;
    prev_sclk = 1'b0; prev_mosi = 1'b0; ready_at = 1'b0; cs_at_done = 1'b0;
    rd_at_done = 8'hxx; got = '0; fin = 1'b0;
    while (!fin && c < int'(70 * d + 10)) begin
      if (c > 0 || !already) @(negedge sys_clk);
      if (c == 0) prev_mosi = mon_mosi;
      if (mon_mosi !== prev_mosi) last_chg = c;
      if (mon_sclk && !prev_sclk) begin
        if (rises < 32) got[31 - rises] = mon_mosi;
        if (c - last_chg < int'(d)) stable_bad++;
        rises++;
      end
      if (!mon_sclk && prev_sclk) falls++;
      if (mon_sclk && mon_cs_n) sclk_bad++;
      if (done_c < 0 && mon_ready) ready_bad++;
      if (mon_done) begin
        if (done_c < 0) begin
          done_c     = c;
          cs_at_done = mon_cs_n;
          rd_at_done = mon_rd;
        end else begin
          extra_done++;
        end
      end
      if (done_c >= 0 && c == done_c + int'(d)) begin
        ready_at = mon_ready;
        if (!gap_chk) fin = 1'b1;
      end
      if (gap_chk && done_c >= 0 && c > done_c && !mon_cs_n) begin
        gap_c = c - done_c;
        fin   = 1'b1;
      end
      spi_miso  = (falls < 32) ? resp_w[31 - falls] : 1'b0;
      prev_sclk = mon_sclk;
      prev_mosi = mon_mosi;
      c++;
    end
`ifdef PI_SPI_MASTER_MISO_EN
    if (rw) exp_rd[sel] = resp;
`endif
    check("done_edge", 32'(done_c + 1), 32'(1 + 66 * d));
    check("sclk_rises", 32'(rises), 32'd32);
    check("mosi_frame", got, frame);
    check("mosi_setup", 32'(stable_bad), 32'd0);
    check("sclk_outside_cs", 32'(sclk_bad), 32'd0);
    check("ready_in_frame", 32'(ready_bad), 32'd0);
    check("done_one_cycle", 32'(extra_done), 32'd0);
    check("cs_n_at_done", 32'(cs_at_done), 32'd1);
    check("rd_data_at_done", 32'(rd_at_done), 32'(exp_rd[sel]));
    check("ready_after_gap", 32'(ready_at), 32'd1);
    if (gap_chk) check("b2b_cs_gap", 32'(gap_c), 32'(d + 1));
  endtask

  initial begin
    int          rises, done_seen;
    logic        prev_sclk;
    bit          sel;
    logic        rw;
    logic [16:0] addr;
    logic [7:0]  data, resp;

    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;

    // Reset values while reset is held.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_a", {26'h0, ready_a, done_a, sclk_a, cs_n_a, mosi_a, ^rd_a === 1'b0 && rd_a == 0},
          32'b1_0_0_1_0_1);
    check("reset_b", {ready_b, done_b, rd_b, sclk_b, cs_n_b, mosi_b}, {1'b1, 1'b0, 8'h00, 3'b010});
    sys_reset_n = 1'b1;

    // Abort a read after its 10th SCLK rise.
    start(1'b0, 1'b1, 17'h0_8000, 8'h00, 1'b0);
    rises = 0;
    prev_sclk = 1'b0;
    for (int i = 0; i < 200 && rises < 10; i++) begin
      @(negedge sys_clk);
      if (sclk_a && !prev_sclk) rises++;
      prev_sclk = sclk_a;
      spi_miso = 1'b1;
    end
    check("abort_reached_rise10", 32'(rises), 32'd10);
    sys_reset_n = 1'b0;
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    check("abort_state", {cs_n_a, sclk_a, ready_a, done_a}, 4'b1010);
    done_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (done_a) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_rd_data", 32'(rd_a), 32'(exp_rd[0]));
    spi_miso = 1'b0;

    // Directed test-plan frames on CLK_DIV=2.
    start(1'b0, 1'b0, 17'h1_2345, 8'hA5, 1'b0);
    watch(1'b0, 1'b0, 32'h0123_45A5, 8'h00, 1'b0, 1'b0);
    start(1'b0, 1'b1, 17'h0_8000, 8'h77, 1'b0);
    watch(1'b0, 1'b1, 32'h8080_0000, 8'h3C, 1'b0, 1'b0);
    start(1'b0, 1'b0, 17'h0_0000, 8'h00, 1'b0);
    watch(1'b0, 1'b0, 32'h0000_0000, 8'hFF, 1'b0, 1'b0);
    start(1'b0, 1'b1, 17'h1_5555, 8'hAA, 1'b0);
    watch(1'b0, 1'b1, 32'h8155_5500, 8'h96, 1'b0, 1'b0);

    // Back-to-back writes with cmd_valid held high.
    start(1'b0, 1'b0, 17'h0_0155, 8'h5A, 1'b1);
    watch(1'b0, 1'b0, 32'h0001_555A, 8'h00, 1'b0, 1'b1);
    valid_a = 1'b0;
    watch(1'b0, 1'b0, 32'h0001_555A, 8'h00, 1'b1, 1'b0);

    // CLK_DIV=1 corner.
    start(1'b1, 1'b0, 17'h1_FFFF, 8'hFF, 1'b0);
    watch(1'b1, 1'b0, 32'h01FF_FFFF, 8'h00, 1'b0, 1'b0);

    // Random frames on both instances.
    for (int i = 0; i < 8; i++) begin
      sel  = i[0];
      rw   = 1'($urandom_range(0, 1));
      addr = 17'($urandom);
      data = 8'($urandom);
      resp = 8'($urandom);
      start(sel, rw, addr, data, 1'b0);
      watch(sel, rw, model_frame(rw, addr, data), resp, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
